// File: rtl/rvfi_retire_buffer_if.sv
// rvfi_retire_buffer_if: RVFI retirement inputs and the drained-entry stream of the retire buffer.
interface rvfi_retire_buffer_if #(parameter int DEPTH = 8);
    logic                   rvfi_valid;
    logic [4:0]             rvfi_rd_addr;
    logic [31:0]            rvfi_rd_wdata;
    logic [4:0]             rvfi_rs1_addr;
    logic [31:0]            rvfi_rs1_rdata;
    logic [4:0]             rvfi_rs2_addr;
    logic [31:0]            rvfi_rs2_rdata;
    logic                   out_valid;
    logic                   out_ready;
    logic [15:0]            out_seq;
    logic [4:0]             out_rd_addr;
    logic [31:0]            out_rd_wdata;
    logic [4:0]             out_rs1_addr;
    logic [31:0]            out_rs1_rdata;
    logic [4:0]             out_rs2_addr;
    logic [31:0]            out_rs2_rdata;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;
    logic [7:0]             drop_cnt;
    modport master (
        output rvfi_valid, rvfi_rd_addr, rvfi_rd_wdata, rvfi_rs1_addr, rvfi_rs1_rdata,
               rvfi_rs2_addr, rvfi_rs2_rdata, out_ready,
        input  out_valid, out_seq, out_rd_addr, out_rd_wdata, out_rs1_addr, out_rs1_rdata,
               out_rs2_addr, out_rs2_rdata, count, overflow, drop_cnt
    );
    modport slave (
        input  rvfi_valid, rvfi_rd_addr, rvfi_rd_wdata, rvfi_rs1_addr, rvfi_rs1_rdata,
               rvfi_rs2_addr, rvfi_rs2_rdata, out_ready,
        output out_valid, out_seq, out_rd_addr, out_rd_wdata, out_rs1_addr, out_rs1_rdata,
               out_rs2_addr, out_rs2_rdata, count, overflow, drop_cnt
    );
endinterface

// File: rtl/rvfi_retire_buffer.sv
// rvfi_retire_buffer: sequence-tagged FIFO of RVFI retirements with sticky overflow and drop count.
// Define RVFI_BUF_FILTER_EN to store only retirements touching register WATCH_REG.
module rvfi_retire_buffer #(
    parameter int DEPTH     = 8,
    parameter int WATCH_REG = 7
) (
    input logic                 clk,
    input logic                 rst,
    rvfi_retire_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef RVFI_BUF_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] seq;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [4:0]  rs1_addr;
        logic [31:0] rs1_rdata;
        logic [4:0]  rs2_addr;
        logic [31:0] rs2_rdata;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [CW-1:0]   r_count;
    logic [15:0]     r_seq;
    logic            r_overflow;
    logic [7:0]      r_drop;

    logic            w_hit;
    logic            w_push_req;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    entry_t          w_head;

    assign w_hit = (bus.rvfi_rd_addr == 5'(WATCH_REG)) || (bus.rvfi_rs1_addr == 5'(WATCH_REG)) ||
                   (bus.rvfi_rs2_addr == 5'(WATCH_REG));
    assign w_push_req = bus.rvfi_valid && (FILTER ? w_hit : 1'b1);
    assign w_full     = r_count == CW'(DEPTH);
    assign w_pop      = (r_count != '0) && bus.out_ready;
    // When full, a same-edge pop frees the slot the push needs.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push && rst)
            r_mem[r_wr] <= '{r_seq, bus.rvfi_rd_addr, bus.rvfi_rd_wdata, bus.rvfi_rs1_addr,
                             bus.rvfi_rs1_rdata, bus.rvfi_rs2_addr, bus.rvfi_rs2_rdata};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_seq      <= '0;
            r_overflow <= 1'b0;
            r_drop     <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (bus.rvfi_valid) r_seq <= r_seq + 16'd1;
            if (w_drop) r_overflow <= 1'b1;
            if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
        end
    end

    // Head fields read as zero whenever the buffer is empty, including after reset.
    assign w_head = (r_count != '0) ? r_mem[r_rd] : '0;

    assign bus.out_valid     = r_count != '0;
    assign bus.out_seq       = w_head.seq;
    assign bus.out_rd_addr   = w_head.rd_addr;
    assign bus.out_rd_wdata  = w_head.rd_wdata;
    assign bus.out_rs1_addr  = w_head.rs1_addr;
    assign bus.out_rs1_rdata = w_head.rs1_rdata;
    assign bus.out_rs2_addr  = w_head.rs2_addr;
    assign bus.out_rs2_rdata = w_head.rs2_rdata;
    assign bus.count         = r_count;
    assign bus.overflow      = r_overflow;
    assign bus.drop_cnt      = r_drop;
endmodule
